// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    // Default operand width in bits.
    localparam int DIV_N = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRIAL = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/divider_control.sv
// Sequencer for the restoring divider: state machine, step counter and
// registered Busy/Done flags. Datapath enables are decoded from state.
module divider_control
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic divisor_zero,
    output logic ld_operands,
    output logic shift_en,
    output logic trial_en,
    output logic last_step,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(N);

    div_state_t    state_q;
    div_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;

    assign ld_operands = (state_q == IDLE) && run;
    assign shift_en    = (state_q == SHIFT);
    assign trial_en    = (state_q == TRIAL);
    assign last_step   = (cnt_q == CW'(N - 1));
    assign busy        = busy_q;
    assign done        = done_q;

    // Next-state, step counter and next values of the Busy/Done flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = divisor_zero ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                state_d = TRIAL;
            end
            TRIAL: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = last_step ? DONE : SHIFT;
            end
            DONE: begin
                // Leave only once Done has been visible and Run has dropped,
                // so a held Run can never launch a second division.
                if (done_q && !run) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Busy stays up through the final trial edge and drops as Done rises.
        busy_d = (state_d == SHIFT) || (state_d == TRIAL) || (state_q == TRIAL);
        // Done is the registered view of DONE, cleared on the exit edge.
        done_d = (state_q == DONE) && (state_d == DONE);
    end

    // State, counter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift and one trial subtract
// per quotient bit, result held until the next Run request.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         Div_By_Zero
);

    logic         ld_operands_s;
    logic         shift_en_s;
    logic         trial_en_s;
    logic         last_step_s;
    logic         divisor_zero_s;

    logic [N:0]   a_q;
    logic [N:0]   a_d;
    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic [N-1:0] d_q;
    logic [N-1:0] d_d;
    logic         dbz_q;
    logic         dbz_d;
    logic [N:0]   diff_s;

    assign divisor_zero_s = (Divisor == {N{1'b0}});

    // Trial subtraction of the divisor from the partial remainder.
    assign diff_s = a_q - {1'b0, d_q};

    divider_control #(.N(N)) u_control (
        .clk          (Clk),
        .reset        (Reset),
        .run          (Run),
        .divisor_zero (divisor_zero_s),
        .ld_operands  (ld_operands_s),
        .shift_en     (shift_en_s),
        .trial_en     (trial_en_s),
        .last_step    (last_step_s),
        .busy         (Busy),
        .done         (Done)
    );

    // Datapath next values: operand load, {A,Q} shift, or trial commit.
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        d_d   = d_q;
        dbz_d = dbz_q;
        if (ld_operands_s) begin
            d_d   = Divisor;
            dbz_d = divisor_zero_s;
            if (divisor_zero_s) begin
                // Saturated quotient; dividend passes through as remainder.
                q_d = {N{1'b1}};
                a_d = {1'b0, Dividend};
            end else begin
                q_d = Dividend;
                a_d = {(N+1){1'b0}};
            end
        end else if (shift_en_s) begin
            a_d = {a_q[N-1:0], q_q[N-1]};
            q_d = {q_q[N-2:0], 1'b0};
        end else if (trial_en_s) begin
            // Commit only a non-negative difference; otherwise A is kept.
            if (!diff_s[N]) begin
                a_d    = diff_s;
                q_d[0] = 1'b1;
            end else begin
                a_d = a_q;
            end
        end else begin
            a_d = a_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q   <= {(N+1){1'b0}};
            q_q   <= {N{1'b0}};
            d_q   <= {N{1'b0}};
            dbz_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            d_q   <= d_d;
            dbz_q <= dbz_d;
        end
    end

    assign Quotient    = q_q;
    assign Remainder   = a_q[N-1:0];
    assign Div_By_Zero = dbz_q;

    // The step index is only needed inside the controller.
    logic unused_s;
    assign unused_s = last_step_s;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (N = 8).
module tb_restoring_divider;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         run;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;

    int n_cmp;
    int n_err;

    restoring_divider #(.N(N)) dut (
        .Clk         (clk),
        .Reset       (reset),
        .Run         (run),
        .Dividend    (dividend),
        .Divisor     (divisor),
        .Quotient    (quotient),
        .Remainder   (remainder),
        .Busy        (busy),
        .Done        (done),
        .Div_By_Zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        tick();
        tick();
        n_cmp++;
        if ({quotient, remainder, busy, done, dbz} !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all zero",
                     quotient, remainder, busy, done, dbz);
        end
        reset = 1'b0;
        tick();
    endtask

    // One division: checks Busy/Done every edge up to completion, then the result.
    // hold_cycles > 0 keeps Run high for that many edges in total.
    task automatic run_div(input string name, input logic [7:0] dvd, input logic [7:0] dvs,
                           input logic [7:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_dbz, input int hold_cycles, input logic scramble);
        int lat;
        lat = (dvs == 8'd0) ? 1 : 17;
        dividend = dvd;
        divisor = dvs;
        run = 1'b1;
        tick();  // edge 0
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) tick();
            if (hold_cycles == 0) run = 1'b0;
            if (scramble) begin
                dividend = 8'($urandom);
                divisor = 8'($urandom);
            end
            n_cmp++;
            if (busy !== ((dvs != 8'd0) && (k < lat)) || done !== (k == lat)) begin
                n_err++;
                $display("FAIL %s_handshake edge %0d: got busy=%b done=%b, want busy=%b done=%b",
                         name, k, busy, done, (dvs != 8'd0) && (k < lat), k == lat);
            end
        end
        n_cmp++;
        if (quotient !== exp_q || remainder !== exp_r || dbz !== exp_dbz) begin
            n_err++;
            $display("FAIL %s_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                     name, quotient, remainder, dbz, exp_q, exp_r, exp_dbz);
        end
        // Keep Run asserted for the rest of the hold window; no restart allowed.
        for (int k = lat + 1; k < hold_cycles; k++) begin
            tick();
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0 || quotient !== exp_q || remainder !== exp_r) begin
                n_err++;
                $display("FAIL %s_hold cycle %0d: got done=%b busy=%b q=%0d r=%0d, want done=1 busy=0 q=%0d r=%0d",
                         name, k, done, busy, quotient, remainder, exp_q, exp_r);
            end
        end
        run = 1'b0;
        tick();  // Done falls, back to IDLE
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== exp_q || remainder !== exp_r) begin
            n_err++;
            $display("FAIL %s_idle: got done=%b busy=%b q=%0d r=%0d, want done=0 busy=0 q=%0d r=%0d",
                     name, done, busy, quotient, remainder, exp_q, exp_r);
        end
    endtask

    task automatic test_basic();
        run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0, 1'b0);
        run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 0, 1'b0);
        run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 0, 1'b0);
        run_div("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 0, 1'b0);
    endtask

    task automatic test_div_by_zero();
        run_div("d200_0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 0, 1'b0);
        run_div("d50_6_after_dbz", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_run_held();
        run_div("d81_9_held", 8'd81, 8'd9, 8'd9, 8'd0, 1'b0, 40, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd9) begin
            n_err++;
            $display("FAIL held_no_restart: got done=%b busy=%b q=%0d, want done=0 busy=0 q=9",
                     done, busy, quotient);
        end
    endtask

    task automatic test_reset_mid();
        dividend = 8'd100;
        divisor = 8'd7;
        run = 1'b1;
        tick();  // edge 0
        run = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        reset = 1'b1;
        tick();  // edge 8 with reset
        n_cmp++;
        if ({quotient, remainder, busy, done, dbz} !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all zero",
                     quotient, remainder, busy, done, dbz);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        run_div("d100_7_after_reset", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_operand_scramble();
        run_div("d173_12_scramble", 8'd173, 8'd12, 8'd14, 8'd5, 1'b0, 0, 1'b1);
        run_div("d99_0_scramble", 8'd99, 8'd0, 8'd255, 8'd99, 1'b1, 0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_run_held();
        test_reset_mid();
        test_operand_scramble();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential unsigned restoring divider: the division counterpart of the lab's shift-add multiplier. It accepts a dividend and divisor on a Run request, produces quotient and remainder after a fixed 2·N+1 cycle sequence, and holds the result until the next request. It sits beside the multiplier behind the same switch/button front end (Run already debounced and synchronized upstream), with results driven to the hex display path.

## Interface
- N, default 8: operand width in bits; legal range 4..16.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high; sampled on rising Clk.
- Run  input  1  level start request (debounced, synchronous to Clk).
- Dividend  input  N  unsigned dividend; sampled only on the start edge.
- Divisor  input  N  unsigned divisor; sampled only on the start edge.
- Quotient  output  N  registered quotient.
- Remainder  output  N  registered remainder.
- Busy  output  1  high while a division is in progress.
- Done  output  1  high in DONE state; result valid.
- Div_By_Zero  output  1  registered; set when the last started division had Divisor = 0.

## Operation
- Registers: A (N+1 bits, partial remainder), Q (N bits, dividend/quotient), D (N bits, divisor), step counter (clog2(N) bits), state.
- States: IDLE, SHIFT, TRIAL, DONE.
- IDLE: Busy=0, Done=0. If Run=1: load D<=Divisor, Q<=Dividend, A<=0, counter<=0, Div_By_Zero<=(Divisor==0). Go to DONE if Divisor==0, otherwise SHIFT.
- Divide-by-zero: on that start edge, Q<=all ones, A<=zero-extended Dividend; the result is Quotient=2^N-1, Remainder=Dividend.
- SHIFT: {A,Q} <= {A,Q} << 1 (Q[0] becomes 0). Go to TRIAL.
- TRIAL: diff = A - {1'b0,D} (N+1 bits). If diff[N]==0, A<=diff and Q[0]<=1; else A and Q are unchanged (the restore is implicit and nothing is written). counter<=counter+1. If counter==N-1, go to DONE; else go to SHIFT.
- DONE: Done=1, Busy=0. Hold all registers. Return to IDLE only when Run=0. A Run held high never triggers a second division.
- Quotient=Q and Remainder=A[N-1:0] at all times. Outputs are meaningful only when Done=1 or after return to IDLE. The result is held in IDLE until the next start.
- Run changes while Busy are ignored. Dividend and Divisor changes after the start edge are ignored.
- Reset in any state, including mid-division, takes effect at the next edge and overrides every other action on that edge.

## Timing
- Reset values: state=IDLE, Quotient=0, Remainder=0, Busy=0, Done=0, Div_By_Zero=0.
- Latency: let edge 0 be the edge where Run=1 is sampled in IDLE. Done is high after edge 2N+1 (edge 17 for N=8). For divide-by-zero, Done is high after edge 1.
- Busy is high from after edge 0 through edge 2N, and falls on the same edge that Done rises.
- Done falls on the first edge that samples Run=0 while in DONE. The earliest new start is the edge after that.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Structure
- Package divider_pkg: state enum typedef (div_state_t: IDLE, SHIFT, TRIAL, DONE) and the default-width constant DIV_N = 8.
- Sub-module divider_control: FSM plus step counter. Outputs to the datapath are ld_operands, shift_en, trial_en, last_step and done.
- Datapath registers and the N+1-bit subtractor live in restoring_divider. The subtractor is a single subtract expression; no separate adder module is used.

## Test plan
- Dividend=100, Divisor=7, Run pulsed high -> exactly 17 edges later Done=1, Quotient=14, Remainder=2, Div_By_Zero=0; Busy high for edges 1..16.
- Dividend=255, Divisor=1 -> Quotient=255, Remainder=0. Then Dividend=5, Divisor=9 -> Quotient=0, Remainder=5.
- Dividend=200, Divisor=0 -> Done after edge 1, Quotient=255, Remainder=200, Div_By_Zero=1. The next valid division clears Div_By_Zero.
- Run held high for 40 cycles with Dividend=81, Divisor=9 -> one division only (Quotient=9, Remainder=0), Done stays high until Run=0, then one edge to IDLE.
- Reset asserted at edge 8 of a division -> next cycle all outputs are zero and state=IDLE. A following 100/7 run completes correctly.
- Dividend and Divisor toggled randomly while Busy -> result matches the operands sampled at the start edge.
